// File: rtl/op_issuer.sv
// op_issuer: posts scalar/op words to the accelerator mailbox and polls for completion.
// Optional OP_ISSUER_TIMEOUT_EN adds an ABORT path once cycles reaches TIMEOUT.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef OP_ADDR
`define OP_ADDR 0
`endif
`ifndef SCALAR_ADDR
`define SCALAR_ADDR 1
`endif

module op_issuer #(
  parameter int unsigned POLL_INTERVAL = 4,
  parameter int unsigned CYC_W = 32,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [`DATA_WIDTH-1:0] cmd_meta,
  input  logic [`DATA_WIDTH-1:0] cmd_scalar,
  output logic [`ADDR_WIDTH-1:0] mem_address,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [`DATA_WIDTH-1:0] mem_writedata,
  input  logic [`DATA_WIDTH-1:0] mem_readdata,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic [CYC_W-1:0]       cycles
);

  localparam int DW = `DATA_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam logic [AW-1:0] OP_A = AW'(`OP_ADDR);
  localparam logic [AW-1:0] SC_A = AW'(`SCALAR_ADDR);

  localparam int unsigned PI = (POLL_INTERVAL < 1) ? 1 : POLL_INTERVAL;
  localparam int WW = $clog2(PI + 1);
  localparam logic [WW-1:0] W_LAST = WW'(PI - 1);

  // op_code occupies the top byte of meta_data_t
  localparam logic [7:0] MAT_ADD      = 8'h01;
  localparam logic [7:0] MAT_ELE_MUL  = 8'h02;
  localparam logic [7:0] MAT_MUL      = 8'h03;
  localparam logic [7:0] MAT_SCAL_MUL = 8'h04;
  localparam logic [7:0] MAT_SCAL_DIV = 8'h05;
  localparam logic [7:0] MAT_SCAL_ADD = 8'h06;
  localparam logic [7:0] MAT_SCAL_INV = 8'h07;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_SCALAR,
    S_WR_OP,
    S_POLL_WAIT,
    S_POLL_RD,
    S_POLL_CHK,
    S_DONE,
    S_ERR
`ifdef OP_ISSUER_TIMEOUT_EN
    , S_ABORT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   meta_q;
  logic [DW-1:0]   scalar_q;
  logic [WW-1:0]   wait_q;
  logic [CYC_W-1:0] cycles_q;
  logic [1:0]      err_code_q;

  logic       accept;
  logic [7:0] op_in;
  logic       is_scal;
  logic       is_mat;
  logic       counting;

  assign cmd_ready = (state_q == S_IDLE) & ~reset;
  assign accept    = cmd_valid & cmd_ready;
  assign busy      = (state_q != S_IDLE);
  assign err_code  = err_code_q;
  assign cycles    = cycles_q;

  assign op_in   = cmd_meta[DW-1 -: 8];
  assign is_scal = (op_in == MAT_SCAL_MUL) | (op_in == MAT_SCAL_DIV)
                 | (op_in == MAT_SCAL_ADD) | (op_in == MAT_SCAL_INV);
  assign is_mat  = (op_in == MAT_ADD) | (op_in == MAT_ELE_MUL)
                 | (op_in == MAT_MUL);

  assign counting = (state_q == S_WR_OP) | (state_q == S_POLL_WAIT)
                  | (state_q == S_POLL_RD) | (state_q == S_POLL_CHK);

  always_comb begin
    state_d       = state_q;
    mem_address   = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_writedata = '0;
    done          = 1'b0;
    err           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_scal: state_d = S_WR_SCALAR;
            is_mat:  state_d = S_WR_OP;
            default: state_d = S_ERR;
          endcase
        end
      end
      S_WR_SCALAR: begin
        mem_write     = 1'b1;
        mem_address   = SC_A;
        mem_writedata = scalar_q;
        state_d       = S_WR_OP;
      end
      S_WR_OP: begin
        mem_write     = 1'b1;
        mem_address   = OP_A;
        mem_writedata = meta_q;
        state_d       = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (wait_q == W_LAST) state_d = S_POLL_RD;
      end
      S_POLL_RD: begin
        mem_read    = 1'b1;
        mem_address = OP_A;
        state_d     = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        if (mem_readdata == '0) state_d = S_DONE;
        else                    state_d = S_POLL_WAIT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err     = 1'b1;
        state_d = S_IDLE;
      end
`ifdef OP_ISSUER_TIMEOUT_EN
      S_ABORT: begin
        mem_write   = 1'b1;
        mem_address = OP_A;
        err         = 1'b1;
        state_d     = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef OP_ISSUER_TIMEOUT_EN
    // a completed op seen in the same check wins over the abort
    if ((state_q == S_POLL_WAIT || state_q == S_POLL_RD ||
         state_q == S_POLL_CHK) &&
        cycles_q >= CYC_W'(TIMEOUT) && state_d != S_DONE)
      state_d = S_ABORT;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      meta_q     <= '0;
      scalar_q   <= '0;
      wait_q     <= '0;
      cycles_q   <= '0;
      err_code_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        meta_q     <= cmd_meta;
        scalar_q   <= cmd_scalar;
        cycles_q   <= '0;
        err_code_q <= '0;
      end else if (counting && cycles_q != '1) begin
        cycles_q <= cycles_q + 1'b1;
      end
      if (state_d == S_ERR) err_code_q <= 2'b01;
`ifdef OP_ISSUER_TIMEOUT_EN
      if (state_d == S_ABORT) err_code_q <= 2'b10;
`endif
      if (state_q == S_WR_OP || state_q == S_POLL_CHK)
        wait_q <= '0;
      else if (state_q == S_POLL_WAIT)
        wait_q <= wait_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_op_issuer.sv
// tb_op_issuer: directed tests for op_issuer against a small mailbox model.
// The model clears the op word 20 cycles after it is posted.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef OP_ADDR
`define OP_ADDR 0
`endif
`ifndef SCALAR_ADDR
`define SCALAR_ADDR 1
`endif

module tb_op_issuer;

  localparam int DW = `DATA_WIDTH;
  localparam int AW = `ADDR_WIDTH;
  localparam logic [AW-1:0] OP_A = AW'(`OP_ADDR);
  localparam logic [AW-1:0] SC_A = AW'(`SCALAR_ADDR);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_meta = '0;
  logic [DW-1:0] cmd_scalar = '0;
  logic [AW-1:0] mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [31:0]   cycles;

  op_issuer #(
    .POLL_INTERVAL(4),
    .CYC_W(32),
    .TIMEOUT(64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_meta(cmd_meta),
    .cmd_scalar(cmd_scalar),
    .mem_address(mem_address),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .cycles(cycles)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int            cyc = 0;
  logic [DW-1:0] op_word = '0;
  logic [DW-1:0] sc_word = '0;
  int            clear_at = -1;
  bit            clear_en = 1'b1;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_write && mem_address == OP_A) begin
      op_word  <= mem_writedata;
      clear_at <= cyc + 20;
    end else if (clear_en && cyc == clear_at) begin
      op_word <= '0;
    end
    if (mem_write && mem_address == SC_A) sc_word <= mem_writedata;
    if (mem_read)
      mem_readdata <= (mem_address == OP_A) ? op_word : sc_word;
    else
      mem_readdata <= '0;
  end

  int          n_opw, opw_cyc, n_zopw, zopw_cyc, n_scw, scw_cyc;
  logic [31:0] opw_data, scw_data, cyc_at_done;
  int          n_rd, rd1, rd2, both_hi;
  int          n_done, done1, done_cyc, n_err, err_cyc;
  logic [1:0]  ec_seen;

  always @(negedge clock) begin
    if (!reset) begin
      if (mem_write && mem_address == OP_A) begin
        if (mem_writedata == '0) begin
          n_zopw   = n_zopw + 1;
          zopw_cyc = cyc;
        end else begin
          if (n_opw == 0) begin
            opw_cyc  = cyc;
            opw_data = mem_writedata;
          end
          n_opw = n_opw + 1;
        end
      end
      if (mem_write && mem_address == SC_A) begin
        n_scw    = n_scw + 1;
        scw_cyc  = cyc;
        scw_data = mem_writedata;
      end
      if (mem_read) begin
        n_rd = n_rd + 1;
        if (n_rd == 1) rd1 = cyc;
        if (n_rd == 2) rd2 = cyc;
        if (mem_write) both_hi = both_hi + 1;
      end
      if (done) begin
        if (n_done == 0) done1 = cyc;
        done_cyc    = cyc;
        cyc_at_done = cycles;
        n_done      = n_done + 1;
      end
      if (err) begin
        n_err   = n_err + 1;
        err_cyc = cyc;
        ec_seen = err_code;
      end
    end
  end

  function automatic logic [31:0] mk(input logic [7:0] op);
    return {op, 12'd16, 12'd8};
  endfunction

  task automatic clear_log;
    n_opw = 0; opw_cyc = -1; n_zopw = 0; zopw_cyc = -1;
    n_scw = 0; scw_cyc = -1; opw_data = '0; scw_data = '0;
    cyc_at_done = '0; n_rd = 0; rd1 = -1; rd2 = -1;
    both_hi = 0; n_done = 0; done1 = -1; done_cyc = -1;
    n_err = 0; err_cyc = -1; ec_seen = '0;
  endtask

  task automatic send(input logic [31:0] m, input logic [31:0] s,
                      input bit hold, output int acc);
    acc        = -1;
    cmd_meta   = m;
    cmd_scalar = s;
    cmd_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clock); #1;
    if (!hold) cmd_valid = 1'b0;
    checks++;
    if (acc < 0) begin
      errors++;
      $display("FAIL accept: command %h not accepted in 100 cycles", m);
    end
  endtask

  task automatic wait_end(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (n_done + n_err > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) begin
      @(posedge clock); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL end_wait: no done/err within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({cmd_ready, busy, mem_read, mem_write, done, err} !== 6'b0 ||
        mem_address !== '0 || mem_writedata !== '0 ||
        err_code !== 2'b00 || cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_vals: rdy=%b busy=%b rd=%b wr=%b addr=%h wd=%h ec=%b cyc=%0d required all 0",
               cmd_ready, busy, mem_read, mem_write, mem_address,
               mem_writedata, err_code, cycles);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b required 1 0",
               cmd_ready, busy);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_mat_add;
    int acc;
    clear_log();
    clear_en = 1'b1;
    send(mk(8'h01), 32'h0, 1'b0, acc);
    wait_end(100);
    checks++;
    if (n_opw !== 1 || opw_cyc !== acc + 1 || opw_data !== mk(8'h01)) begin
      errors++;
      $display("FAIL add_opwrite: n=%0d at=%0d data=%h required 1 %0d %h",
               n_opw, opw_cyc - acc, opw_data, 1, mk(8'h01));
    end
    checks++;
    if (n_scw !== 0 || both_hi !== 0) begin
      errors++;
      $display("FAIL add_noscalar: scw=%0d both=%0d required 0 0",
               n_scw, both_hi);
    end
    checks++;
    if (rd1 !== acc + 6 || rd2 !== acc + 12 || n_rd !== 4) begin
      errors++;
      $display("FAIL add_polls: rd1=+%0d rd2=+%0d n=%0d required +6 +12 4",
               rd1 - acc, rd2 - acc, n_rd);
    end
    checks++;
    if (n_done !== 1 || done_cyc !== acc + 26 || n_err !== 0) begin
      errors++;
      $display("FAIL add_done: n=%0d at=+%0d err=%0d required 1 +26 0",
               n_done, done_cyc - acc, n_err);
    end
    checks++;
    if (cyc_at_done !== 32'd25 || cycles !== 32'd25 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_cycles: at_done=%0d held=%0d busy=%b required 25 25 0",
               cyc_at_done, cycles, busy);
    end
  endtask

  task automatic test_scalar;
    int acc;
    clear_log();
    clear_en = 1'b1;
    send(mk(8'h05), 32'h40000000, 1'b0, acc);
    wait_end(100);
    checks++;
    if (n_scw !== 1 || scw_cyc !== acc + 1 || scw_data !== 32'h40000000) begin
      errors++;
      $display("FAIL scal_write: n=%0d at=+%0d data=%h required 1 +1 40000000",
               n_scw, scw_cyc - acc, scw_data);
    end
    checks++;
    if (n_opw !== 1 || opw_cyc !== acc + 2 || opw_data !== mk(8'h05)) begin
      errors++;
      $display("FAIL scal_opwrite: n=%0d at=+%0d data=%h required 1 +2 %h",
               n_opw, opw_cyc - acc, opw_data, mk(8'h05));
    end
    checks++;
    if (n_done !== 1 || done_cyc !== acc + 27 || cyc_at_done !== 32'd25) begin
      errors++;
      $display("FAIL scal_done: n=%0d at=+%0d cyc=%0d required 1 +27 25",
               n_done, done_cyc - acc, cyc_at_done);
    end
  endtask

  task automatic test_bad_op;
    logic [7:0] codes [2] = '{8'h00, 8'h09};
    int acc;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      send(mk(codes[k]), 32'h0, 1'b0, acc);
      @(negedge clock);
      checks++;
      if (err !== 1'b1 || err_code !== 2'b01 || cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_err op=%h: err=%b ec=%b rdy=%b required 1 01 0",
                 codes[k], err, err_code, cmd_ready);
      end
      @(negedge clock);
      checks++;
      if (cmd_ready !== 1'b1 || err !== 1'b0 || err_code !== 2'b01) begin
        errors++;
        $display("FAIL bad_ready op=%h: rdy=%b err=%b ec=%b required 1 0 01",
                 codes[k], cmd_ready, err, err_code);
      end
      @(posedge clock); #1;
      checks++;
      if (n_rd !== 0 || n_opw + n_zopw + n_scw !== 0 ||
          n_err !== 1 || err_cyc !== acc + 1) begin
        errors++;
        $display("FAIL bad_traffic op=%h: rd=%0d wr=%0d nerr=%0d at=+%0d required 0 0 1 +1",
                 codes[k], n_rd, n_opw + n_zopw + n_scw, n_err, err_cyc - acc);
      end
    end
  endtask

  task automatic test_reset_mid;
    int acc;
    clear_log();
    clear_en = 1'b0;
    send(mk(8'h03), 32'h0, 1'b0, acc);
    @(posedge clock); #1;
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({cmd_ready, busy, mem_read, mem_write, done, err} !== 6'b0 ||
        mem_address !== '0 || mem_writedata !== '0 ||
        err_code !== 2'b00 || cycles !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b busy=%b rd=%b wr=%b cyc=%0d required all 0",
               cmd_ready, busy, mem_read, mem_write, cycles);
    end
    @(posedge clock); #1 reset = 1'b0;
    repeat (5) begin
      @(posedge clock); #1;
    end
    checks++;
    if (n_opw !== 1 || n_zopw !== 0 || op_word !== mk(8'h03)) begin
      errors++;
      $display("FAIL mid_posted: n=%0d zero=%0d word=%h required 1 0 %h",
               n_opw, n_zopw, op_word, mk(8'h03));
    end
    clear_log();
    clear_en = 1'b1;
    send(mk(8'h01), 32'h0, 1'b0, acc);
    wait_end(100);
    checks++;
    if (n_done !== 1 || done_cyc !== acc + 26 || opw_cyc !== acc + 1) begin
      errors++;
      $display("FAIL mid_next: n=%0d done=+%0d wr=+%0d required 1 +26 +1",
               n_done, done_cyc - acc, opw_cyc - acc);
    end
  endtask

  task automatic test_timeout;
    int acc;
    clear_log();
    clear_en = 1'b0;
    send(mk(8'h03), 32'h0, 1'b0, acc);
`ifdef OP_ISSUER_TIMEOUT_EN
    wait_end(200);
    checks++;
    if (n_err !== 1 || ec_seen !== 2'b10 || n_zopw !== 1 ||
        zopw_cyc !== err_cyc || n_done !== 0) begin
      errors++;
      $display("FAIL abort: nerr=%0d ec=%b zw=%0d zat=%0d eat=%0d done=%0d required 1 10 1 same 0",
               n_err, ec_seen, n_zopw, zopw_cyc, err_cyc, n_done);
    end
`else
    for (int i = 0; i < 1100; i++) begin
      if (cyc >= acc + 1000) break;
      @(posedge clock); #1;
    end
    checks++;
    if (busy !== 1'b1 || n_done !== 0 || n_err !== 0) begin
      errors++;
      $display("FAIL no_timeout: busy=%b done=%0d err=%0d required 1 0 0",
               busy, n_done, n_err);
    end
`endif
    #3 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    clear_en = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    int acc1;
    int acc2 = -1;
    clear_log();
    clear_en = 1'b1;
    send(mk(8'h03), 32'h0, 1'b1, acc1);
    cmd_meta = mk(8'h01);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        acc2 = cyc;
        break;
      end
    end
    @(posedge clock); #1 cmd_valid = 1'b0;
    checks++;
    if (n_done !== 1 || acc2 !== done1 + 1 || acc2 !== acc1 + 27) begin
      errors++;
      $display("FAIL b2b_accept: ndone=%0d acc2=+%0d done1=+%0d required 1 +27 +26",
               n_done, acc2 - acc1, done1 - acc1);
    end
    for (int i = 0; i < 100; i++) begin
      if (n_done >= 2) break;
      @(posedge clock); #1;
    end
    checks++;
    if (n_done !== 2 || done_cyc !== acc2 + 26 || n_err !== 0) begin
      errors++;
      $display("FAIL b2b_second: ndone=%0d at=+%0d err=%0d required 2 +26 0",
               n_done, done_cyc - acc2, n_err);
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_mat_add();
    test_scalar();
    test_bad_op();
    test_reset_mid();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
